sha256_msg_scheduler: RTL and testbench

// Producer side of the hash datapath interface. It accepts a message as 512-bit chunks of 16 x 32-bit words on a

---
 rtl/sha256_msg_scheduler.sv | 179 +++++++++++++++++
 tb/tb_sha256_msg_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_scheduler.sv
// sha256_msg_scheduler: accepts 512-bit chunks as 16 x 32-bit words on a
// valid/ready stream, expands each chunk into the SHA-256 message schedule
// with a 16-word sliding window, and drives wk/round plus the strobes that
// step the hash register file.
module sha256_msg_scheduler #(
   parameter int NUM_ROUNDS = 64,
   parameter int ROUND_W    = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               msg_start,
   input  logic               word_valid,
   input  logic [31:0]        word_data,
   input  logic               word_last,
   output logic               word_ready,
   output logic               start,
   output logic               hash_enable,
   output logic [31:0]        wk,
   output logic [ROUND_W-1:0] round,
   output logic               chunk_done,
   output logic               msg_done,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_LOAD  = 3'd2,
      S_ROUND = 3'd3,
      S_CDONE = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   localparam logic [31:0] K_TAB [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

   // small sigma functions of the schedule recurrence
   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
   endfunction

   state_t             state_r;
   state_t             state_nxt_s;
   logic [3:0]         cnt_r;
   logic               last_r;
   logic [31:0]        win_r     [16];
   logic [31:0]        win_nxt_s [16];
   logic               xfer_s;
   logic               start_nxt_s;
   logic               ready_nxt_s;
   logic               hen_nxt_s;
   logic               cdone_nxt_s;
   logic               mdone_nxt_s;
   logic               busy_nxt_s;
   logic [ROUND_W-1:0] round_nxt_s;
   logic [31:0]        wk_nxt_s;

   assign xfer_s = word_valid & word_ready & (state_r == S_LOAD);

   // next-state decode of the chunk sequencing FSM
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (msg_start) state_nxt_s = S_START;
            else           state_nxt_s = S_IDLE;
         end
         S_START: state_nxt_s = S_LOAD;
         S_LOAD: begin
            if (xfer_s && (cnt_r == 4'd15)) state_nxt_s = S_ROUND;
            else                            state_nxt_s = S_LOAD;
         end
         S_ROUND: begin
            if (round == LAST_ROUND) state_nxt_s = S_CDONE;
            else                     state_nxt_s = S_ROUND;
         end
         S_CDONE: begin
            if (last_r) state_nxt_s = S_FIN;
            else        state_nxt_s = S_LOAD;
         end
         S_FIN:   state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // next window contents: load words during LOAD, slide and extend during ROUND
   always_comb begin
      for (int i = 0; i < 16; i++) win_nxt_s[i] = win_r[i];
      if (xfer_s) begin
         win_nxt_s[cnt_r] = word_data;
      end else if (state_r == S_ROUND) begin
         for (int i = 0; i < 15; i++) win_nxt_s[i] = win_r[i + 1];
         win_nxt_s[15] = sig1(win_r[14]) + win_r[9] + sig0(win_r[1]) + win_r[0];
      end else begin
         win_nxt_s[0] = win_r[0];
      end
   end

   // output values for the upcoming state, registered on the next edge
   always_comb begin
      start_nxt_s = (state_nxt_s == S_START);
      ready_nxt_s = (state_nxt_s == S_LOAD);
      hen_nxt_s   = (state_nxt_s == S_ROUND);
      cdone_nxt_s = (state_nxt_s == S_CDONE);
      mdone_nxt_s = (state_nxt_s == S_FIN);
      busy_nxt_s  = (state_nxt_s != S_IDLE);
      round_nxt_s = round;
      wk_nxt_s    = 32'h0000_0000;
      if (state_nxt_s == S_ROUND) begin
         if (state_r == S_ROUND) round_nxt_s = round + ROUND_W'(1);
         else                    round_nxt_s = '0;
         wk_nxt_s = win_nxt_s[0] + K_TAB[round_nxt_s[5:0]];
      end else begin
         round_nxt_s = round;
      end
   end

   // state register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= S_IDLE;
         word_ready  <= 1'b0;
         start       <= 1'b0;
         hash_enable <= 1'b0;
         wk          <= 32'h0000_0000;
         round       <= '0;
         chunk_done  <= 1'b0;
         msg_done    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         word_ready  <= ready_nxt_s;
         start       <= start_nxt_s;
         hash_enable <= hen_nxt_s;
         wk          <= wk_nxt_s;
         round       <= round_nxt_s;
         chunk_done  <= cdone_nxt_s;
         msg_done    <= mdone_nxt_s;
         busy        <= busy_nxt_s;
      end
   end

   // word counter, final-chunk flag and schedule window
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r  <= 4'd0;
         last_r <= 1'b0;
         for (int i = 0; i < 16; i++) win_r[i] <= 32'h0000_0000;
      end else begin
         for (int i = 0; i < 16; i++) win_r[i] <= win_nxt_s[i];
         if (state_r == S_START) begin
            cnt_r  <= 4'd0;
            last_r <= 1'b0;
         end else if (xfer_s) begin
            cnt_r <= cnt_r + 4'd1;
            if (cnt_r == 4'd15) last_r <= word_last;
            else                last_r <= last_r;
         end else begin
            cnt_r  <= cnt_r;
            last_r <= last_r;
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Self-checking bench for sha256_msg_scheduler: drives padded messages with
// optional random backpressure, compares the wk/round stream against a
// schedule computed directly from the SHA-256 recurrence, and folds the DUT
// wk stream through a behavioural hash to check the final digest.
module tb_sha256_msg_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        msg_start;
   logic        word_valid;
   logic [31:0] word_data;
   logic        word_last;
   logic        word_ready;
   logic        start;
   logic        hash_enable;
   logic [31:0] wk;
   logic [7:0]  round;
   logic        chunk_done;
   logic        msg_done;
   logic        busy;

   sha256_msg_scheduler #(.NUM_ROUNDS(64), .ROUND_W(8)) dut (
      .clk(clk), .reset(reset), .msg_start(msg_start), .word_valid(word_valid),
      .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
      .start(start), .hash_enable(hash_enable), .wk(wk), .round(round),
      .chunk_done(chunk_done), .msg_done(msg_done), .busy(busy)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] DIG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DIG_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   logic [31:0] ktab [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [31:0]  msg_q [$];
   logic [39:0]  exp_q [$];
   logic [39:0]  obs_q [$];
   logic [255:0] hh, st, dut_digest, ref_digest;
   int  n_start, n_cdone, n_mdone, n_xfer, extra_xfer;
   int  excl_viol, wk_idle_viol, busy_viol, round_hold_viol, ready_viol;
   int  start_cyc, first_xfer, last_xfer, first_he, last_he, cdone_cyc, mdone_cyc;
   bit  in_msg = 1'b0;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ss0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ss1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // one compression round on packed working state {a,b,c,d,e,f,g,h}
   function automatic logic [255:0] round_step(input logic [255:0] s, input logic [31:0] wkv);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + wkv;
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
      return r;
   endfunction

   // reference schedule and digest computed straight from the message words
   task automatic build_ref(input int nchunks);
      logic [31:0]  w [64];
      logic [255:0] h, s;
      exp_q.delete();
      h = IV;
      for (int c = 0; c < nchunks; c++) begin
         for (int t = 0; t < 16; t++) w[t] = msg_q[c*16 + t];
         for (int t = 16; t < 64; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
         s = h;
         for (int t = 0; t < 64; t++) begin
            exp_q.push_back({8'(t), w[t] + ktab[t]});
            s = round_step(s, w[t] + ktab[t]);
         end
         h = add8(h, s);
      end
      ref_digest = h;
   endtask

   // monitor: behavioural hash_block driven by the DUT strobes
   task automatic observe();
      int hot;
      hot = int'(start) + int'(hash_enable) + int'(chunk_done) + int'(msg_done);
      if (hot > 1) excl_viol++;
      if (!hash_enable && (wk != 32'h0)) wk_idle_viol++;
      if (in_msg && !busy) busy_viol++;
      if (hash_enable && word_ready) ready_viol++;
      if (start) begin
         n_start++; start_cyc = cyc; hh = IV; in_msg = 1'b1;
      end
      if (hash_enable) begin
         obs_q.push_back({round, wk});
         if (first_he < 0) first_he = cyc;
         last_he = cyc;
         if (round == 8'd0) st = hh;
         st = round_step(st, wk);
      end
      if (chunk_done) begin
         n_cdone++; cdone_cyc = cyc;
         if (round != 8'd63) round_hold_viol++;
         hh = add8(hh, st);
      end
      if (msg_done) begin
         n_mdone++; mdone_cyc = cyc; dut_digest = hh; in_msg = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      observe();
   endtask

   task automatic load_abc();
      msg_q.delete();
      msg_q.push_back(32'h61626380);
      for (int i = 0; i < 14; i++) msg_q.push_back(32'h0);
      msg_q.push_back(32'h00000018);
   endtask

   task automatic load_two();
      logic [31:0] base;
      msg_q.delete();
      base = 32'h61626364;
      for (int i = 0; i < 14; i++) begin
         msg_q.push_back(base);
         base = base + 32'h01010101;
      end
      msg_q.push_back(32'h80000000);
      for (int i = 0; i < 16; i++) msg_q.push_back(32'h0);
      msg_q.push_back(32'h000001c0);
   endtask

   task automatic load_rand(input int nchunks);
      msg_q.delete();
      for (int i = 0; i < nchunks*16; i++) msg_q.push_back($urandom);
   endtask

   // run one message; abort asserts reset at round 30, disturb pokes msg_start/word_valid during ROUND
   task automatic run_msg(input int nchunks, input bit gaps, input bit disturb, input bit abort,
                          input logic [255:0] known, input bit use_known);
      int widx, gap_left, guard, total;
      total = nchunks * 16;
      n_start = 0; n_cdone = 0; n_mdone = 0; n_xfer = 0; extra_xfer = 0;
      excl_viol = 0; wk_idle_viol = 0; busy_viol = 0; round_hold_viol = 0; ready_viol = 0;
      start_cyc = -1; first_xfer = -1; last_xfer = -1; first_he = -1; last_he = -1;
      cdone_cyc = -1; mdone_cyc = -1; in_msg = 1'b0; dut_digest = '0;
      obs_q.delete();
      build_ref(nchunks);
      word_valid = 1'b0;
      msg_start  = 1'b1;
      cyc = 0;
      tick();
      msg_start = 1'b0;
      widx = 0;
      gap_left = gaps ? int'($urandom_range(0, 5)) : 0;
      guard = 0;
      while ((n_mdone == 0) && (guard < 3000)) begin
         if (abort && hash_enable && (round == 8'd30)) begin
            reset = 1'b1;
            word_valid = 1'b0;
            tick();
            check_val("reset_mid_round",
                      {word_ready, start, hash_enable, wk, round, chunk_done, msg_done, busy}, '0);
            check_val("reset_busy", busy, 1'b0);
            reset = 1'b0;
            return;
         end
         msg_start = 1'b0;
         if (widx < total) begin
            if (gap_left > 0) begin
               word_valid = 1'b0;
               word_data  = $urandom;
               gap_left--;
            end else begin
               word_valid = 1'b1;
               word_data  = msg_q[widx];
               word_last  = ((widx / 16) == (nchunks - 1));
            end
            if (word_valid && word_ready) begin
               if (first_xfer < 0) first_xfer = cyc;
               last_xfer = cyc;
               n_xfer++;
               widx++;
               gap_left = gaps ? int'($urandom_range(0, 5)) : 0;
            end
         end else if (disturb && hash_enable) begin
            word_valid = 1'b1;
            word_data  = $urandom;
            word_last  = 1'b0;
            msg_start  = (round >= 8'd10) && (round < 8'd13);
            if (word_ready) extra_xfer++;
         end else begin
            word_valid = 1'b0;
         end
         tick();
         guard++;
      end
      word_valid = 1'b0;
      msg_start  = 1'b0;
      check_val("msg_done_seen", n_mdone, 1);
      tick();
      check_val("idle_after_msg", busy, 1'b0);
      check_val("wk_count", obs_q.size(), exp_q.size());
      for (int i = 0; (i < exp_q.size()) && (i < obs_q.size()); i++)
         check_val($sformatf("round_wk[%0d]", i), obs_q[i], exp_q[i]);
      check_val("start_count", n_start, 1);
      check_val("chunk_done_count", n_cdone, nchunks);
      check_val("words_taken", n_xfer, total);
      check_val("extra_words", extra_xfer, 0);
      check_val("ready_in_round", ready_viol, 0);
      check_val("strobe_exclusive", excl_viol, 0);
      check_val("wk_zero_idle", wk_idle_viol, 0);
      check_val("busy_in_msg", busy_viol, 0);
      check_val("round_hold_cdone", round_hold_viol, 0);
      if (use_known) check_val("digest_known", dut_digest, known);
      else           check_val("digest_ref", dut_digest, ref_digest);
   endtask

   initial begin
      reset = 1'b1; msg_start = 1'b1; word_valid = 1'b1;
      word_data = 32'hdeadbeef; word_last = 1'b0;
      repeat (3) tick();
      check_val("reset_outputs",
                {word_ready, start, hash_enable, wk, round, chunk_done, msg_done, busy}, '0);
      reset = 1'b0; msg_start = 1'b0;
      repeat (3) tick();
      check_val("idle_no_start", {start, busy, word_ready}, 3'b000);
      word_valid = 1'b0;

      // "abc", no gaps: exact cycle timing
      load_abc();
      run_msg(1, 1'b0, 1'b0, 1'b0, DIG_ABC, 1'b1);
      check_val("t_start", start_cyc, 1);
      check_val("t_first_word", first_xfer, 2);
      check_val("t_last_word", last_xfer, 17);
      check_val("t_first_round", first_he, 18);
      check_val("t_last_round", last_he, 81);
      check_val("t_chunk_done", cdone_cyc, 82);
      check_val("t_msg_done", mdone_cyc, 83);
      if (obs_q.size() > 15) begin
         check_val("abc_wk_r0", obs_q[0], {8'd0, 32'hA3EC9318});
         check_val("abc_wk_r15", obs_q[15], {8'd15, 32'hC19BF18C});
      end

      // two-chunk message
      load_two();
      run_msg(2, 1'b0, 1'b0, 1'b0, DIG_TWO, 1'b1);
      check_val("two_msg_done_count", n_mdone, 1);

      // backpressure on "abc"
      load_abc();
      run_msg(1, 1'b1, 1'b0, 1'b0, DIG_ABC, 1'b1);

      // reset mid-round, then a clean message
      load_abc();
      run_msg(1, 1'b0, 1'b0, 1'b1, DIG_ABC, 1'b1);
      load_abc();
      run_msg(1, 1'b0, 1'b0, 1'b0, DIG_ABC, 1'b1);

      // msg_start and word_valid poked during ROUND
      load_abc();
      run_msg(1, 1'b0, 1'b1, 1'b0, DIG_ABC, 1'b1);

      // random multi-chunk messages with gaps
      for (int m = 0; m < 3; m++) begin
         int nch;
         nch = int'($urandom_range(1, 3));
         load_rand(nch);
         run_msg(nch, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
